// File: rtl/fa_bist_pkg.sv
// Shared types and sizing for the full-adder BIST checker.
// Covers the sequencing states, vector count and counter widths.
package fa_bist_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;
    localparam int ERR_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

endpackage

// File: rtl/fa_golden.sv
// Reference full adder that produces the expected sum and carry
// for the vector currently being driven.
module fa_golden (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic x,
    output logic y
);

    assign x = a ^ b ^ c;
    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/fa_bist_checker.sv
// Exhaustive 8-vector BIST for an external full adder: drive, settle, sample, report.
//   state     | meaning
//   ST_IDLE   | stimulus parked at 0, waiting for start
//   ST_DRIVE  | holding current vector for SETTLE_CYCLES cycles
//   ST_SAMPLE | compare DUT sum/carry against golden, advance vector
//   ST_DONE   | publish pass and pulse done, then back to idle
module fa_bist_checker
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    input  logic             x_i,
    input  logic             y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       fail_vec
);

    bist_state_e      state, state_nxt;
    logic [VEC_W-1:0] vec, vec_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [7:0]       fail_nxt;
    logic             pass_nxt, done_nxt;
    logic [2:0]       stim_nxt;
    logic             exp_x, exp_y, mismatch;

    fa_golden u_golden (
        .a (a_o),
        .b (b_o),
        .c (c_o),
        .x (exp_x),
        .y (exp_y)
    );

    // Case inequality so an X/Z on the response also counts as a failure in simulation
    assign mismatch = (x_i !== exp_x) || (y_i !== exp_y);
    assign busy     = (state == ST_DRIVE) || (state == ST_SAMPLE);

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        cnt_nxt   = cnt;
        err_nxt   = err_count;
        fail_nxt  = fail_vec;
        pass_nxt  = pass;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_DRIVE;
                    vec_nxt   = '0;
                    cnt_nxt   = '0;
                    err_nxt   = '0;
                    fail_nxt  = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt == 4'(SETTLE_CYCLES - 1)) begin
                    state_nxt = ST_SAMPLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    fail_nxt[vec] = 1'b1;
                    if (err_count != ERR_W'(NUM_VECTORS))
                        err_nxt = err_count + 1'b1;
                end
                if (vec == VEC_W'(NUM_VECTORS - 1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_DRIVE;
                    vec_nxt   = vec + 1'b1;
                    cnt_nxt   = '0;
                end
            end
            ST_DONE: begin
                done_nxt  = 1'b1;
                pass_nxt  = (err_count == '0);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Stimulus is registered from the next vector so the pins only move on clock edges
        stim_nxt = ((state_nxt == ST_DRIVE) || (state_nxt == ST_SAMPLE)) ? vec_nxt : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            vec             <= '0;
            cnt             <= '0;
            err_count       <= '0;
            fail_vec        <= '0;
            pass            <= 1'b0;
            done            <= 1'b0;
            {a_o, b_o, c_o} <= 3'd0;
        end else begin
            state           <= state_nxt;
            vec             <= vec_nxt;
            cnt             <= cnt_nxt;
            err_count       <= err_nxt;
            fail_vec        <= fail_nxt;
            pass            <= pass_nxt;
            done            <= done_nxt;
            {a_o, b_o, c_o} <= stim_nxt;
        end
    end

endmodule
